// File: rtl/dispense_pkg.sv
// Shared types and constants for the candy dispense sequencer.
// States, amount codes and DC motor direction encodings.
package dispense_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] AMT_SMALL   = 2'b00;
  localparam logic [1:0] AMT_MED     = 2'b01;
  localparam logic [1:0] AMT_LARGE   = 2'b10;
  localparam logic [1:0] AMT_INVALID = 2'b11;

  localparam logic [1:0] DC_FWD  = 2'b01;
  localparam logic [1:0] DC_STOP = 2'b10;

endpackage

// File: rtl/dispense_sequencer_sync2.sv
// Generic two-flop synchroniser for asynchronous Pi GPIO inputs.
// Both stages reset to zero.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // two-stage metastability filter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/dispense_sequencer.sv
// Counted stepper + DC chute sequencing for one candy dispense.
// Optional DISPENSE_STATS_EN adds a saturating completion counter.
module dispense_sequencer
  import dispense_pkg::*;
#(
  parameter int SMALL_STEPS = 200,
  parameter int MED_STEPS   = 400,
  parameter int LARGE_STEPS = 800,
  parameter int CNT_W       = 12,
  parameter int RUN_TICKS   = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_tick,
  input  logic        dc_pwm_in,
  input  logic        candyflag,
  input  logic [1:0]  amount,
  output logic        stepper_step,
  output logic        stepper_dir,
  output logic [2:0]  dcmotor,
  output logic        handshake,
  output logic        busy,
`ifdef DISPENSE_STATS_EN
  output logic [15:0] dispense_count,
`endif
  output logic        err
);

  logic       cf_s;
  logic [1:0] amt_s;
  logic       req_rise;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic       step_q, step_d;
  logic       err_q, err_d;
  logic       hs_q, hs_d;
  logic       busy_q, busy_d;
  logic       cf_prev_q;

  sync2 #(.W(1)) u_sync_cf (
    .clk (clk),
    .rst (rst),
    .d   (candyflag),
    .q   (cf_s)
  );

  sync2 #(.W(2)) u_sync_amt (
    .clk (clk),
    .rst (rst),
    .d   (amount),
    .q   (amt_s)
  );

  assign req_rise = cf_s & ~cf_prev_q;

  function automatic logic [CNT_W-1:0] amt_target(input logic [1:0] a);
    logic [CNT_W-1:0] t;
    t = CNT_W'(SMALL_STEPS);
    case (a)
      AMT_MED:   t = CNT_W'(MED_STEPS);
      AMT_LARGE: t = CNT_W'(LARGE_STEPS);
      default:   t = CNT_W'(SMALL_STEPS);
    endcase
    return t;
  endfunction

  // state, counter and output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      step_cnt_q <= '0;
      run_cnt_q  <= '0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      hs_q       <= 1'b0;
      busy_q     <= 1'b0;
      cf_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      step_cnt_q <= step_cnt_d;
      run_cnt_q  <= run_cnt_d;
      step_q     <= step_d;
      err_q      <= err_d;
      hs_q       <= hs_d;
      busy_q     <= busy_d;
      cf_prev_q  <= cf_s;
    end
  end

  // next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    step_cnt_d = step_cnt_q;
    run_cnt_d  = run_cnt_q;
    step_d     = step_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        step_d = 1'b0;
        if (!cf_s) err_d = 1'b0;
        if (req_rise) begin
          if (amt_s == AMT_INVALID) begin
            err_d = 1'b1;
          end else begin
            target_d   = amt_target(amt_s);
            step_cnt_d = '0;
            run_cnt_d  = '0;
            state_d    = STEP;
          end
        end
      end
      STEP: begin
        if (!cf_s) begin
          state_d = IDLE;
          step_d  = 1'b0;
        end else if (step_tick) begin
          step_d = ~step_q;
          if (step_q) begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
            if (step_cnt_q + CNT_W'(1) == target_q) begin
              state_d   = RUN;
              run_cnt_d = '0;
            end
          end
        end
      end
      RUN: begin
        step_d = 1'b0;
        if (!cf_s) begin
          state_d = IDLE;
        end else if (step_tick) begin
          if (run_cnt_q == CNT_W'(RUN_TICKS - 1)) begin
            state_d = DONE;
          end else begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        step_d = 1'b0;
        if (!cf_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        step_d  = 1'b0;
      end
    endcase
    busy_d = (state_d == STEP) || (state_d == RUN);
    hs_d   = (state_d == DONE);
  end

`ifdef DISPENSE_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // count completed dispenses, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == RUN && state_d == DONE && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  // completion counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign dispense_count = cnt_q;
`endif

  assign stepper_step = step_q;
  assign stepper_dir  = 1'b0;
  assign busy         = busy_q;
  assign handshake    = hs_q;
  assign err          = err_q;
  assign dcmotor      = busy_q ? {dc_pwm_in & busy_q, DC_FWD}
                               : {1'b0, DC_STOP};

endmodule

// File: tb/tb_dispense_sequencer.sv
// Self-checking bench for dispense_sequencer with reduced step counts.
// Expected pulse counts are queued per request and checked at completion.
module tb_dispense_sequencer;

  localparam int SMALL = 4;
  localparam int MED   = 8;
  localparam int LARGE = 16;
  localparam int RUNT  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       step_tick = 1'b0;
  logic       dc_pwm_in = 1'b0;
  logic       candyflag;
  logic [1:0] amount;
  logic       stepper_step;
  logic       stepper_dir;
  logic [2:0] dcmotor;
  logic       handshake;
  logic       busy;
  logic       err;
`ifdef DISPENSE_STATS_EN
  logic [15:0] dispense_count;
`endif

  int tests_run = 0;
  int fails = 0;
  int pulses = 0;
  int busy_ticks = 0;
  int dir_bad = 0;
  int div = 0;
  logic step_prev = 1'b0;
  int exp_q[$];

  dispense_sequencer #(
    .SMALL_STEPS (SMALL),
    .MED_STEPS   (MED),
    .LARGE_STEPS (LARGE),
    .CNT_W       (12),
    .RUN_TICKS   (RUNT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .step_tick    (step_tick),
    .dc_pwm_in    (dc_pwm_in),
    .candyflag    (candyflag),
    .amount       (amount),
    .stepper_step (stepper_step),
    .stepper_dir  (stepper_dir),
    .dcmotor      (dcmotor),
    .handshake    (handshake),
    .busy         (busy),
`ifdef DISPENSE_STATS_EN
    .dispense_count (dispense_count),
`endif
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (stepper_step === 1'b1 && step_prev === 1'b0) pulses++;
      step_prev = stepper_step;
      if (busy === 1'b1 && dcmotor[1:0] !== 2'b01) dir_bad++;
      dc_pwm_in = ~dc_pwm_in;
      div = (div + 1) % 4;
      step_tick = (div == 3);
      if (step_tick && busy === 1'b1) busy_ticks++;
    end
  end

  task automatic clr_mon();
    pulses = 0;
    busy_ticks = 0;
    dir_bad = 0;
  endtask

  task automatic wait_hs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (handshake === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_req(input string nm, input int ticks);
    bit ok;
    int e;
    wait_hs(ok);
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL %s handshake timeout: got 0 want 1", nm);
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    tests_run++;
    if (pulses !== e) begin
      fails++;
      $display("FAIL %s pulses: got %0d want %0d", nm, pulses, e);
    end
    tests_run++;
    if (busy_ticks !== ticks) begin
      fails++;
      $display("FAIL %s busy ticks: got %0d want %0d", nm, busy_ticks, ticks);
    end
    tests_run++;
    if (dir_bad !== 0 || stepper_dir !== 1'b0) begin
      fails++;
      $display("FAIL %s dc dir: got %0d bad want 0", nm, dir_bad);
    end
  endtask

  task automatic drop_check_hs(input string nm);
    candyflag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (handshake !== 1'b1) begin
      fails++;
      $display("FAIL %s hs early: got %b want 1", nm, handshake);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (handshake !== 1'b0) begin
      fails++;
      $display("FAIL %s hs drop: got %b want 0", nm, handshake);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    candyflag = 1'b0;
    amount = 2'b00;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({stepper_step, stepper_dir, dcmotor, handshake, busy, err}
        !== 8'b00_010_000) begin
      fails++;
      $display("FAIL reset outs: got %b want 00010000",
        {stepper_step, stepper_dir, dcmotor, handshake, busy, err});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_small();
    clr_mon();
    amount = 2'b00;
    candyflag = 1'b1;
    exp_q.push_back(SMALL);
    finish_req("small", 2 * SMALL + RUNT);
    drop_check_hs("small");
  endtask

  task automatic test_large_amount_change();
    int n;
    clr_mon();
    amount = 2'b10;
    candyflag = 1'b1;
    exp_q.push_back(LARGE);
    n = 0;
    while (pulses < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    amount = 2'b00;
    finish_req("large", 2 * LARGE + RUNT);
    drop_check_hs("large");
  endtask

  task automatic test_invalid();
    clr_mon();
    amount = 2'b11;
    candyflag = 1'b1;
    repeat (20) @(negedge clk);
    tests_run++;
    if (err !== 1'b1 || pulses !== 0 || dcmotor !== 3'b010 || busy !== 1'b0) begin
      fails++;
      $display("FAIL invalid: got err=%b p=%0d dc=%b want err=1 p=0 dc=010",
        err, pulses, dcmotor);
    end
    candyflag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL invalid err early: got %b want 1", err);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL invalid err clear: got %b want 0", err);
    end
    amount = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort();
    int n;
    clr_mon();
    amount = 2'b01;
    candyflag = 1'b1;
    n = 0;
    while (pulses < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    candyflag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || stepper_step !== 1'b0 || dcmotor !== 3'b010) begin
      fails++;
      $display("FAIL abort: got busy=%b st=%b dc=%b want 0 0 010",
        busy, stepper_step, dcmotor);
    end
    repeat (40) @(negedge clk);
    tests_run++;
    if (handshake !== 1'b0 || pulses !== 2) begin
      fails++;
      $display("FAIL abort hs: got hs=%b p=%0d want hs=0 p=2",
        handshake, pulses);
    end
  endtask

  task automatic test_retrigger();
    clr_mon();
    amount = 2'b00;
    candyflag = 1'b1;
    exp_q.push_back(SMALL);
    finish_req("retrig1", 2 * SMALL + RUNT);
    clr_mon();
    repeat (50) @(negedge clk);
    tests_run++;
    if (pulses !== 0 || busy_ticks !== 0 || handshake !== 1'b1) begin
      fails++;
      $display("FAIL retrig hold: got p=%0d bt=%0d hs=%b want 0 0 1",
        pulses, busy_ticks, handshake);
    end
    drop_check_hs("retrig1");
    clr_mon();
    candyflag = 1'b1;
    exp_q.push_back(SMALL);
    finish_req("retrig2", 2 * SMALL + RUNT);
    drop_check_hs("retrig2");
  endtask

  task automatic test_reset_mid_run();
    int n;
    clr_mon();
    amount = 2'b00;
    candyflag = 1'b1;
    n = 0;
    while (!(pulses == SMALL && stepper_step === 1'b0 && busy === 1'b1)
           && n < 500) begin
      @(negedge clk);
      n++;
    end
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({stepper_step, stepper_dir, dcmotor, handshake, busy, err}
        !== 8'b00_010_000) begin
      fails++;
      $display("FAIL rst mid run: got %b want 00010000",
        {stepper_step, stepper_dir, dcmotor, handshake, busy, err});
    end
    candyflag = 1'b0;
    repeat (3) @(negedge clk);
`ifdef DISPENSE_STATS_EN
    tests_run++;
    if (dispense_count !== 16'd0) begin
      fails++;
      $display("FAIL stats rst: got %0d want 0", dispense_count);
    end
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      clr_mon();
      candyflag = 1'b1;
      exp_q.push_back(SMALL);
      finish_req("post rst", 2 * SMALL + RUNT);
      drop_check_hs("post rst");
    end
`ifdef DISPENSE_STATS_EN
    tests_run++;
    if (dispense_count !== 16'd2) begin
      fails++;
      $display("FAIL stats count: got %0d want 2", dispense_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_small();
    test_large_amount_change();
    test_invalid();
    test_abort();
    test_retrigger();
    test_reset_mid_run();
    tests_run++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
